// File: rtl/shoot_sound_player.sv
// Sound-sample ROM read master: on play, walks words 0..NUM_SAMPLES-1, attenuates
// each sample and hands it to the audio codec over a valid/ready stream.
module shoot_sound_player #(
    parameter int NUM_SAMPLES = 17000,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              stop,
    input  logic [2:0]        vol_shift,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] aud_data,
    output logic              aud_valid,
    input  logic              aud_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic              pending_play;
    logic              pending_stop;
    logic [DATA_W-1:0] sample_reg;
    logic              done_q;

    logic handshake;
    logic eff_stop;
    logic eff_play;

    // A request arriving in the handshake cycle must act at that handshake,
    // so the live inputs are folded in with the latched flags; stop beats play.
    assign handshake = (state == HOLD) && aud_ready;
    assign eff_stop  = pending_stop | stop;
    assign eff_play  = pending_play | (play & ~stop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            addr         <= '0;
            pending_play <= 1'b0;
            pending_stop <= 1'b0;
            // NOTE: sample_reg drives aud_data directly, so it is reset to keep
            // aud_data at zero whenever reset is asserted.
            sample_reg   <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state != IDLE) begin
                pending_stop <= eff_stop;
                pending_play <= eff_play;
            end
            case (state)
                IDLE: begin
                    if (play) begin
                        addr  <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    sample_reg <= DATA_W'($signed(mem_readdata) >>> vol_shift);
                    state      <= HOLD;
                end
                HOLD: begin
                    if (handshake) begin
                        if (eff_stop) begin
                            pending_stop <= 1'b0;
                            pending_play <= 1'b0;
                            state        <= IDLE;
                        end else if (eff_play) begin
                            pending_stop <= 1'b0;
                            pending_play <= 1'b0;
                            addr         <= '0;
                            state        <= FETCH;
                        end else if (addr == LAST_ADDR) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_address    = addr;
    assign mem_chipselect = (state == FETCH);
    assign mem_clken      = (state == FETCH) || (state == WAIT);
    assign aud_data       = sample_reg;
    assign aud_valid      = (state == HOLD);
    assign busy           = (state != IDLE);
    assign done           = done_q;

endmodule

// File: tb/tb_shoot_sound_player.sv
// Directed bench for shoot_sound_player with a one-cycle-latency ROM model.
module tb_shoot_sound_player;

    localparam int N = 17000;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        stop;
    logic [2:0]  vol_shift;
    logic [14:0] mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic [15:0] mem_readdata;
    logic [15:0] aud_data;
    logic        aud_valid;
    logic        aud_ready;
    logic        busy;
    logic        done;

    logic [15:0] rom [0:N-1];
    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_clken && int'(mem_address) < N) mem_readdata <= rom[mem_address];

    shoot_sound_player dut (
        .clk(clk), .reset(reset), .play(play), .stop(stop), .vol_shift(vol_shift),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .aud_data(aud_data), .aud_valid(aud_valid),
        .aud_ready(aud_ready), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) done_seen++;
    endtask

    task automatic rom_init();
        for (int i = 0; i < N; i++) rom[i] = 16'(i);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_play();
        play = 1'b1;
        tick();
        play = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !aud_valid; i++) tick();
        check(tag, aud_valid, 1);
    endtask

    task automatic accept();
        aud_ready = 1'b1;
        tick();
        aud_ready = 1'b0;
    endtask

    // Runs with ready high until word w sits in HOLD, then drops ready so it stalls.
    task automatic run_to(input int w, input string tag);
        aud_ready = 1'b1;
        for (int i = 0; i < 3 * w + 20 && !(aud_valid && aud_data == 16'(w)); i++) tick();
        aud_ready = 1'b0;
        check(tag, {aud_valid, aud_data}, {1'b1, 16'(w)});
    endtask

    initial begin
        int n, busy_cnt, last_hs, done_cyc, done_cnt, bad_data, bad_gap, d0;
        reset = 1'b1; play = 1'b0; stop = 1'b0; vol_shift = 3'd0; aud_ready = 1'b0;
        rom_init();
        #1;
        check("rst_async_outs", {mem_address, mem_chipselect, mem_clken, aud_data, aud_valid, busy, done}, 0);
        do_reset();
        check("rst_outs", {mem_address, mem_chipselect, mem_clken, aud_data, aud_valid, busy, done}, 0);

        // Full playback, ready tied high.
        aud_ready = 1'b1;
        pulse_play();
        n = 0; busy_cnt = 0; last_hs = -10; done_cyc = -1; done_cnt = 0; bad_data = 0; bad_gap = 0;
        for (int c = 0; c < 52000; c++) begin
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = c; end
            if (aud_valid && aud_ready) begin
                if (aud_data != 16'(n)) bad_data++;
                if (n > 0 && c - last_hs != 3) bad_gap++;
                last_hs = c;
                n++;
            end
            if (!busy && n == N) break;
            tick();
        end
        check("full_count", n, N);
        check("full_data_bad", bad_data, 0);
        check("full_gap_bad", bad_gap, 0);
        check("full_busy_cycles", busy_cnt, 3 * N);
        check("full_done_count", done_cnt, 1);
        check("full_done_cycle", done_cyc, last_hs + 1);
        check("full_last_addr", mem_address, N - 1);
        tick();
        check("full_done_low", {done, busy}, 0);

        // Attenuation with sign extension.
        aud_ready = 1'b0;
        rom[0] = 16'h8000; rom[1] = 16'h0010;
        vol_shift = 3'd3;
        pulse_play();
        wait_valid("att0_valid");
        check("att0_data", aud_data, 16'hF000);
        vol_shift = 3'd4;
        accept();
        wait_valid("att1_valid");
        check("att1_data", aud_data, 16'h0001);
        vol_shift = 3'd0;
        do_reset();
        rom_init();

        // Backpressure on word 5.
        rom[5] = 16'h7FFF;
        pulse_play();
        for (int i = 0; i < 5; i++) begin
            wait_valid("bp_pre_valid");
            accept();
        end
        wait_valid("bp_w5_valid");
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {aud_valid, aud_data, mem_chipselect}, {1'b1, 16'h7FFF, 1'b0});
            tick();
        end
        aud_ready = 1'b1;
        tick();
        aud_ready = 1'b0;
        check("bp_next_fetch", {mem_chipselect, mem_address}, {1'b1, 15'd6});
        do_reset();
        rom_init();

        // Retrigger during word 100.
        rom[0] = 16'h1234;
        d0 = done_seen;
        pulse_play();
        run_to(100, "rt_reach_100");
        play = 1'b1;
        tick();
        play = 1'b0;
        tick();
        check("rt_no_truncate", {aud_valid, aud_data}, {1'b1, 16'd100});
        accept();
        check("rt_restart_addr", {mem_chipselect, mem_address}, {1'b1, 15'd0});
        wait_valid("rt_w0_valid");
        check("rt_w0_data", aud_data, 16'h1234);
        check("rt_no_done", done_seen, d0);

        // Stop during word 200 (still in the retriggered run).
        run_to(200, "st_reach_200");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("st_still_valid", {aud_valid, aud_data}, {1'b1, 16'd200});
        accept();
        check("st_idle", {busy, done, aud_valid}, 0);
        tick(); tick();
        check("st_stays_idle", busy, 0);
        check("st_no_done", done_seen, d0);

        // Play restarts at 0, then play+stop together during word 200.
        pulse_play();
        check("ps_restart_addr", {mem_chipselect, mem_address}, {1'b1, 15'd0});
        run_to(200, "ps_reach_200");
        play = 1'b1; stop = 1'b1;
        tick();
        play = 1'b0; stop = 1'b0;
        check("ps_still_valid", {aud_valid, aud_data}, {1'b1, 16'd200});
        accept();
        check("ps_idle", {busy, done, aud_valid}, 0);
        for (int i = 0; i < 5; i++) tick();
        check("ps_stays_idle", busy, 0);
        check("ps_no_done", done_seen, d0);
        pulse_play();
        wait_valid("ps_replay_valid");
        check("ps_replay_data", aud_data, 16'h1234);

        // Async reset asserted in WAIT mid-stream.
        aud_ready = 1'b1;
        rom[0] = 16'h0ABC;
        for (int i = 0; i < 40 && !(mem_clken && !mem_chipselect && mem_address == 15'd7); i++) tick();
        check("ar_in_wait", {mem_clken, mem_chipselect, mem_address}, {1'b1, 1'b0, 15'd7});
        reset = 1'b1;
        #1;
        check("ar_outs_zero", {mem_address, mem_chipselect, mem_clken, aud_data, aud_valid, busy, done}, 0);
        #2;
        reset = 1'b0;
        aud_ready = 1'b0;
        tick(); tick(); tick();
        check("ar_idle", {busy, aud_valid, mem_address}, 0);
        pulse_play();
        check("ar_restart_addr", {mem_chipselect, mem_address}, {1'b1, 15'd0});
        wait_valid("ar_w0_valid");
        check("ar_w0_data", aud_data, 16'h0ABC);
        check("ar_no_done", done_seen, d0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shoot_sound_player.md
Name: shoot_sound_player

Overview:
- Read-side master for the single-port sound-sample ROM: 16-bit signed PCM, 15-bit word address, 17000 words, one-cycle read latency.
- On a play trigger it walks the ROM from word 0 to word NUM_SAMPLES-1.
- Each sample gets an optional attenuation shift and is handed to the audio-codec sink over a valid/ready stream.
- Sits between the game-control logic (tank-fire event) and the audio output path.

Parameters:
- NUM_SAMPLES, 17000: number of sample words played per trigger.
- ADDR_W, 15: ROM word-address width.
- DATA_W, 16: sample width, two's complement.

Ports:
- clk  in  1  system clock; ROM shares this clock.
- reset  in  1  asynchronous, active-high reset.
- play  in  1  single-cycle trigger: start, or restart, playback.
- stop  in  1  single-cycle abort request.
- vol_shift  in  3  attenuation; sample is arithmetic-shifted right by this amount, 0 = full scale.
- mem_address  out  ADDR_W  ROM word address.
- mem_chipselect  out  1  ROM access strobe.
- mem_clken  out  1  ROM clock enable.
- mem_readdata  in  DATA_W  ROM data, valid the cycle after the address is presented.
- aud_data  out  DATA_W  sample to the codec.
- aud_valid  out  1  aud_data is valid.
- aud_ready  in  1  codec accepts the sample this cycle.
- busy  out  1  playback in progress (state != IDLE).
- done  out  1  one-cycle pulse on natural completion only.

Behaviour:
- Reset values (async assert, sync release): state IDLE; addr 0; pending_play 0; pending_stop 0.
- Reset values of all outputs: mem_address 0, mem_chipselect 0, mem_clken 0, aud_data 0, aud_valid 0, busy 0, done 0.
- Reset mid-playback aborts immediately; done is not pulsed.
- FSM states: IDLE, FETCH, WAIT, HOLD.
- IDLE: on play, addr<=0 and go to FETCH. stop is ignored.
- FETCH (1 cycle): mem_address=addr, mem_chipselect=1, mem_clken=1. Go to WAIT.
- WAIT (1 cycle): mem_clken=1. At the end of the cycle: sample_reg <= mem_readdata >>> vol_shift (sign-extending), vol_shift sampled this cycle. Go to HOLD.
- HOLD: aud_valid=1, aud_data=sample_reg, both stable until aud_valid&aud_ready.
- On handshake in HOLD, priority order:
  1. pending_stop: go to IDLE, clear both pending flags, no done.
  2. pending_play: addr<=0, go to FETCH, clear pending_play.
  3. addr==NUM_SAMPLES-1: done=1 for one cycle, go to IDLE.
  4. Otherwise: addr<=addr+1, go to FETCH.
- play or stop arriving in FETCH/WAIT/HOLD sets pending_play or pending_stop. A request arriving in the same cycle as the handshake takes effect at that handshake.
- play and stop in the same cycle: stop wins; pending_play is not set.
- A retrigger never truncates an in-flight sample; aud_valid never drops before acceptance.
- Minimum interval between accepted samples: 3 cycles (FETCH, WAIT, HOLD with aud_ready high).
- The address counter never exceeds NUM_SAMPLES-1 and never wraps; mem_address holds its last value when idle.
- mem_chipselect is asserted only in FETCH. No write path exists.
- busy=1 in FETCH/WAIT/HOLD. It drops in the cycle after the final handshake, together with done.

Test Plan:
- Reset, then play with aud_ready tied 1, ROM word n = n:
  - aud_data sequence 0,1,2,…,16999, one sample every 3 cycles.
  - done pulses once, 1 cycle after the handshake of 16999.
  - busy high for 51000 cycles.
- Backpressure: aud_ready low for 10 cycles while in HOLD with word 5 = 0x7FFF:
  - aud_valid stays 1 and aud_data stays 0x7FFF throughout.
  - Next fetch address is 6 only after aud_ready rises.
- Attenuation: word 0 = 0x8000, vol_shift=3 → aud_data 0xF000. Word 1 = 0x0010, vol_shift=4 → 0x0001.
- Retrigger: play pulsed while HOLD shows word 100 → word 100 is still delivered, next sample is word 0, done is not pulsed at the retrigger.
- Stop, and play plus stop in the same cycle, during word 200:
  - Word 200 is delivered, then IDLE, busy=0, done=0.
  - A later single play restarts at word 0.
- Async reset asserted in WAIT mid-stream → all outputs 0 immediately. After release, idle until play; playback restarts at word 0.
